elevator_button_conditioner: RTL and testbench
==============================================

// Module: elevator_button_conditioner
// PURPOSE
//  Input stage ahead of the elevator top level. Takes raw asynchronous push-button lines
//  (4 hall + 3 car buttons), synchronises and debounces each one.
//  Emits a single-cycle press pulse per debounced rising edge into the *_button_pressed inputs.
//  One identical channel per button; channels are fully independent.
// PARAMETERS
//  NUM_BTN          7     number of button channels (index map in elevator_pkg)
//  DEBOUNCE_CYCLES  16    consecutive cycles the synced level must differ before it is accepted (>=1)
//  STUCK_CYCLES     1024  held-high cycles before a stuck flag asserts (used only with the macro)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        asynchronous, active-high reset
//  btn_raw    in   NUM_BTN  raw button lines, asynchronous to clk, 1 = pressed
//  btn_pulse  out  NUM_BTN  1-cycle pulse per accepted press, to *_button_pressed
//  btn_level  out  NUM_BTN  debounced button level
//  btn_stuck  out  NUM_BTN  button held >= STUCK_CYCLES (tied 0 without the macro)
// BEHAVIOUR
//  Reset: sync1, sync2, deb, cnt, held_cnt, btn_pulse, btn_level and btn_stuck all go to 0 immediately.
//  Per channel i, every edge:
//  - Sync: sync1 <= btn_raw[i]; sync2 <= sync1 (2-FF, no logic between the flops).
//  - Debounce, case sync2 == deb: cnt <= 0.
//  - Debounce, case sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2, cnt <= 0.
//  - Debounce, case sync2 != deb otherwise: cnt <= cnt+1.
//  - Counter width: CNT_W = $clog2(DEBOUNCE_CYCLES+1). cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//  - btn_level[i] = deb (registered).
//  - btn_pulse[i] <= 1 exactly on the edge where deb goes 0->1, else 0. No pulse on release.
//  Latency: raw change set up before edge 1 is reflected on btn_level/btn_pulse after edge
//    2+DEBOUNCE_CYCLES.
//  Boundary conditions:
//  - Glitch: a change lasting < DEBOUNCE_CYCLES synced cycles resets cnt; deb is unchanged, no pulse.
//  - Bounce: any toggle restarts the count. Exactly one pulse per accepted press.
//  - Simultaneous presses on different channels produce pulses on the same cycle.
//  - Reset mid-count: all state cleared. A button still held after reset deasserts is treated as a
//    new press, with a pulse after 2+DEBOUNCE_CYCLES edges.
//  - Metastability lives in sync1 only. deb, cnt and outputs are driven from sync2 only.
// CONFIGURATION
//  Macro: ELEVATOR_BTN_STUCK_DETECT_EN.
//  Defined:
//  - Per-channel held_cnt, width $clog2(STUCK_CYCLES+1).
//  - held_cnt increments each cycle deb==1 and saturates at STUCK_CYCLES; cleared when deb==0.
//  - btn_stuck[i] <= (held_cnt == STUCK_CYCLES). It clears the edge after deb falls.
//  - btn_pulse and btn_level are unaffected.
//  Undefined: no held_cnt logic; btn_stuck is constant 0. The port list is identical in both cases.
// STRUCTURE
//  elevator_pkg holds:
//  - NUM_BUTTONS = 7.
//  - Index constants: BTN_F1_UP=0, BTN_F2_UP=1, BTN_F2_DN=2, BTN_F3_DN=3, BTN_CAR_F1=4, BTN_CAR_F2=5,
//    BTN_CAR_F3=6.
//  - Default DEBOUNCE_CYCLES and STUCK_CYCLES.
//  Sub-module button_debounce_ch holds one channel: sync, debounce and pulse, plus the optional
//  stuck counter. The top instantiates NUM_BTN copies in a generate loop; the top has no other logic.
// TESTING  (DEBOUNCE_CYCLES=4, STUCK_CYCLES=8; edge numbers count from the first edge after the
//          stimulus change)
//  1. Assert rst for 3 cycles with btn_raw random -> all outputs 0 during and after reset while
//     btn_raw=0.
//  2. btn_raw[0] 0->1 and held -> btn_pulse[0]=1 for exactly one cycle after edge 6;
//     btn_level[0]=1 from edge 6. Release -> level 0 after 6 edges, no pulse.
//  3. btn_raw[3] high for 3 cycles then low -> btn_pulse[3] and btn_level[3] stay 0 throughout.
//  4. btn_raw[2] pattern 1,0,1,1,0 then held 1 -> one pulse only, 6 edges after the final 0->1.
//  5. btn_raw[1] and btn_raw[5] rise on the same cycle -> both pulses on the same cycle (edge 6);
//     other bits stay 0.
//  6. btn_raw[4] held; rst pulsed at edge 4 -> outputs 0 asynchronously. Pulse appears 6 edges
//     after rst falls.
//  7. With ELEVATOR_BTN_STUCK_DETECT_EN: btn_raw[6] held -> btn_stuck[6]=1 from edge 15.
//     Release -> btn_stuck[6] clears one edge after btn_level[6] falls.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator input stage: button index map and default timing.
package elevator_pkg;
    localparam int NUM_BUTTONS       = 7;
    localparam int DEF_DEBOUNCE_CYC  = 16;
    localparam int DEF_STUCK_CYC     = 1024;

    localparam int BTN_F1_UP  = 0;
    localparam int BTN_F2_UP  = 1;
    localparam int BTN_F2_DN  = 2;
    localparam int BTN_F3_DN  = 3;
    localparam int BTN_CAR_F1 = 4;
    localparam int BTN_CAR_F2 = 5;
    localparam int BTN_CAR_F3 = 6;
endpackage

// File: rtl/elevator_button_conditioner_if.sv
// Button bundle between the raw switch inputs and the conditioned press outputs.
interface elevator_button_conditioner_if #(parameter int NUM_BTN = 7);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_stuck;

    modport master (output btn_raw, input btn_pulse, input btn_level, input btn_stuck);
    modport slave  (input btn_raw, output btn_pulse, output btn_level, output btn_stuck);
endinterface

// File: rtl/elevator_button_conditioner_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, press pulse and
// optional stuck detector (ELEVATOR_BTN_STUCK_DETECT_EN).
module button_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level,
    output logic stuck
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2, deb;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // sync2 is the only synchronised view of raw; nothing downstream looks at sync1.
    assign accept = (sync2 != deb) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= accept && sync2;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (accept) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = deb;

`ifdef ELEVATOR_BTN_STUCK_DETECT_EN
    localparam int HELD_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [HELD_W-1:0] HELD_MAX = HELD_W'(STUCK_CYCLES);

    logic [HELD_W-1:0] held_cnt;

    // Gating with deb drops the flag on the edge right after the debounced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_cnt <= '0;
            stuck    <= 1'b0;
        end else begin
            stuck <= deb && (held_cnt == HELD_MAX);
            if (!deb)
                held_cnt <= '0;
            else if (held_cnt != HELD_MAX)
                held_cnt <= held_cnt + 1'b1;
        end
    end
`else
    assign stuck = 1'b0;
`endif
endmodule

// File: rtl/elevator_button_conditioner.sv
// Input stage: NUM_BTN independent debounce channels feeding *_button_pressed.
// Stuck-button flags need ELEVATOR_BTN_STUCK_DETECT_EN; otherwise btn_stuck is 0.
module elevator_button_conditioner
    import elevator_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYC,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYC
) (
    input logic clk,
    input logic rst,
    elevator_button_conditioner_if.slave bus
);
    logic [NUM_BTN-1:0] pulse_v, level_v, stuck_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .pulse (pulse_v[i]),
            .level (level_v[i]),
            .stuck (stuck_v[i])
        );
    end

    assign bus.btn_pulse = pulse_v;
    assign bus.btn_level = level_v;
    assign bus.btn_stuck = stuck_v;
endmodule

// File: tb/tb_elevator_button_conditioner.sv
// Directed bench for elevator_button_conditioner (DEBOUNCE_CYCLES=4, STUCK_CYCLES=8)
// with a pulse scoreboard; stuck checks follow ELEVATOR_BTN_STUCK_DETECT_EN.
module tb_elevator_button_conditioner;
    localparam int NB = 7;

    typedef struct {
        int            cyc;
        logic [NB-1:0] mask;
    } pulse_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    pulse_exp_t exp_q[$];

    elevator_button_conditioner_if #(.NUM_BTN(NB)) bus ();

    elevator_button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor: every pulse the DUT shows must match the next expected entry.
    always @(negedge clk) begin
        if (bus.btn_pulse != '0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pulse_unexpected: cyc=%0d got=%b expected=none", cyc, bus.btn_pulse);
            end else begin
                pulse_exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.mask != bus.btn_pulse) begin
                    fails++;
                    $display("FAIL pulse_match: got cyc=%0d mask=%b expected cyc=%0d mask=%b",
                             cyc, bus.btn_pulse, e.cyc, e.mask);
                end
            end
        end
`ifndef ELEVATOR_BTN_STUCK_DETECT_EN
        tests++;
        if (bus.btn_stuck != '0) begin
            fails++;
            $display("FAIL stuck_tied0: cyc=%0d got=%b expected=0", cyc, bus.btn_stuck);
        end
`endif
    end

    initial begin
        int c0, c1;
        logic bad;
        logic [4:0] pat;

        // 1: reset with random inputs
        bus.btn_raw = NB'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("reset_pulse", 32'(bus.btn_pulse), 0);
            check("reset_level", 32'(bus.btn_level), 0);
        end
        bus.btn_raw = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_level", 32'(bus.btn_level), 0);
        end

        // 2: clean press and release on channel 0
        c0 = cyc;
        bus.btn_raw[0] = 1'b1;
        exp_q.push_back('{c0 + 6, 7'b0000001});
        wait_until(c0 + 5);
        check("press_level_e5", 32'(bus.btn_level[0]), 0);
        wait_until(c0 + 6);
        check("press_level_e6", 32'(bus.btn_level[0]), 1);
        wait_until(c0 + 10);
        c1 = cyc;
        bus.btn_raw[0] = 1'b0;
        wait_until(c1 + 5);
        check("release_level_e5", 32'(bus.btn_level[0]), 1);
        wait_until(c1 + 6);
        check("release_level_e6", 32'(bus.btn_level[0]), 0);
        wait_until(c1 + 8);

        // 3: 3-cycle glitch on channel 3
        c0 = cyc;
        bad = 1'b0;
        bus.btn_raw[3] = 1'b1;
        wait_until(c0 + 3);
        bus.btn_raw[3] = 1'b0;
        while (cyc < c0 + 12) begin
            @(negedge clk);
            if (bus.btn_level[3]) bad = 1'b1;
        end
        check("glitch_level", 32'(bad), 0);

        // 4: bounce 1,0,1,1,0 then held on channel 2
        pat = 5'b01101;
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            bus.btn_raw[2] = pat[k];
            @(negedge clk);
        end
        c1 = cyc;
        bus.btn_raw[2] = 1'b1;
        exp_q.push_back('{c1 + 6, 7'b0000100});
        wait_until(c1 + 5);
        check("bounce_level_e5", 32'(bus.btn_level[2]), 0);
        wait_until(c1 + 10);
        check("bounce_level_held", 32'(bus.btn_level[2]), 1);
        bus.btn_raw[2] = 1'b0;
        wait_until(c1 + 20);

        // 5: simultaneous presses on channels 1 and 5
        c0 = cyc;
        bus.btn_raw[1] = 1'b1;
        bus.btn_raw[5] = 1'b1;
        exp_q.push_back('{c0 + 6, 7'b0100010});
        wait_until(c0 + 6);
        check("simul_level", 32'(bus.btn_level), 32'h22);
        wait_until(c0 + 8);

        // 6: reset mid-count on channel 4 while 1 and 5 are still held
        c0 = cyc;
        bus.btn_raw[4] = 1'b1;
        wait_until(c0 + 3);
        rst = 1'b1;
        #1;
        check("async_rst_level", 32'(bus.btn_level), 0);
        check("async_rst_pulse", 32'(bus.btn_pulse), 0);
        @(negedge clk);
        @(negedge clk);
        c1 = cyc;
        rst = 1'b0;
        exp_q.push_back('{c1 + 6, 7'b0110010});
        wait_until(c1 + 5);
        check("rst_repress_e5", 32'(bus.btn_level), 0);
        wait_until(c1 + 6);
        check("rst_repress_e6", 32'(bus.btn_level), 32'h32);
        bus.btn_raw = '0;
        wait_until(c1 + 16);
        check("all_released", 32'(bus.btn_level), 0);

        // 7: long hold on channel 6
        c0 = cyc;
        bus.btn_raw[6] = 1'b1;
        exp_q.push_back('{c0 + 6, 7'b1000000});
        wait_until(c0 + 14);
        check("stuck_e14", 32'(bus.btn_stuck[6]), 0);
        wait_until(c0 + 15);
`ifdef ELEVATOR_BTN_STUCK_DETECT_EN
        check("stuck_e15", 32'(bus.btn_stuck[6]), 1);
`else
        check("stuck_e15", 32'(bus.btn_stuck[6]), 0);
`endif
        wait_until(c0 + 20);
        c1 = cyc;
        bus.btn_raw[6] = 1'b0;
        wait_until(c1 + 6);
        check("stuck_rel_level", 32'(bus.btn_level[6]), 0);
`ifdef ELEVATOR_BTN_STUCK_DETECT_EN
        check("stuck_rel_e6", 32'(bus.btn_stuck[6]), 1);
`else
        check("stuck_rel_e6", 32'(bus.btn_stuck[6]), 0);
`endif
        wait_until(c1 + 7);
        check("stuck_rel_e7", 32'(bus.btn_stuck[6]), 0);
        wait_until(c1 + 10);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
